param_update_sched: RTL

- Sits between the SPI memory interface (host write side) and the parameter memory write port.
- Buffers host parameter writes in a FIFO, grouped into batches.
- Commits only complete batches, and only inside a fixed per-sample window of the DSP program counter. A coefficient set therefore never changes part-way through a sample frame.
- One word is written to parameter memory per clock while draining.

---
 rtl/param_update_sched.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/param_update_sched.sv
// Parameter-write scheduler: buffers host writes in batches and commits whole
// batches to parameter memory only inside the per-sample commit window.
module param_update_sched #(
  parameter int WORD_WIDTH   = 36,
  parameter int ADDR_WIDTH   = 10,
  parameter int PC_WIDTH     = 11,
  parameter int FIFO_DEPTH   = 16,
  parameter int WINDOW_START = 0,
  parameter int WINDOW_LEN   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic                  host_wr_en,
  input  logic [ADDR_WIDTH-1:0] host_wr_addr,
  input  logic [WORD_WIDTH-1:0] host_wr_data,
  input  logic                  host_wr_last,
  output logic                  host_ready,
  output logic                  param_wr_en,
  output logic [ADDR_WIDTH-1:0] param_wr_addr,
  output logic [WORD_WIDTH-1:0] param_wr_data,
  output logic                  busy,
  output logic                  overflow,
  output logic                  batch_split
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ADDR_WIDTH + WORD_WIDTH;

  localparam logic [CW-1:0]       DEPTH_C     = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0]       ONE_C       = CW'(1);
  localparam logic [PC_WIDTH-1:0] WIN_START_C = PC_WIDTH'(WINDOW_START);

  // A full FIFO must drain completely before the DSP resumes reading memory.
  if (WINDOW_LEN < FIFO_DEPTH + 1) begin : g_bad_window
    $error("param_update_sched: WINDOW_LEN must be >= FIFO_DEPTH+1");
  end
  if ((1 << PW) != FIFO_DEPTH) begin : g_bad_depth
    $error("param_update_sched: FIFO_DEPTH must be a power of 2");
  end

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]     r_count, r_open_len, r_complete, r_drain_cnt;
  logic [CW-1:0]     w_drain_cnt_nxt, w_complete_nxt, w_open_len_nxt;
  logic              w_pop, w_push, w_full, w_force;
  logic [EW-1:0]     w_head;

  logic                  r_wr_en, r_busy, r_overflow, r_batch_split;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [WORD_WIDTH-1:0] r_wr_data;

  assign w_full  = (r_count == DEPTH_C);
  // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
  assign w_push  = host_wr_en && (!w_full || w_pop);
  // Nothing closed and no room left: close the open batch to avoid deadlock.
  assign w_force = w_full && (r_complete == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // The first pop happens in the start cycle so the first write lands at
  // WINDOW_START+1; drain_cnt then counts the words still to pop.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    w_pop           = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (pc == WIN_START_C && r_complete != '0) begin
          w_pop           = 1'b1;
          w_drain_cnt_nxt = r_complete - ONE_C;
          if (r_complete != ONE_C) w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_pop           = 1'b1;
        w_drain_cnt_nxt = r_drain_cnt - ONE_C;
        if (r_drain_cnt == ONE_C) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_complete_nxt = r_complete;
    w_open_len_nxt = r_open_len;
    if (w_force) begin
      w_complete_nxt = r_open_len;
      w_open_len_nxt = '0;
    end else begin
      if (w_push) begin
        if (host_wr_last) begin
          w_complete_nxt = r_complete + r_open_len + ONE_C;
          w_open_len_nxt = '0;
        end else begin
          w_open_len_nxt = r_open_len + ONE_C;
        end
      end
      if (w_pop) w_complete_nxt = w_complete_nxt - ONE_C;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_open_len    <= '0;
      r_complete    <= '0;
      r_drain_cnt   <= '0;
      r_wr_en       <= 1'b0;
      r_busy        <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_overflow    <= 1'b0;
      r_batch_split <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
      r_complete  <= w_complete_nxt;
      r_open_len  <= w_open_len_nxt;
      r_wr_en     <= w_pop;
      r_busy      <= w_pop;
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + PW'(1);
        r_wr_addr <= w_head[EW-1:WORD_WIDTH];
        r_wr_data <= w_head[WORD_WIDTH-1:0];
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
      if (host_wr_en && !w_push) r_overflow    <= 1'b1;
      if (w_force)               r_batch_split <= 1'b1;
    end
  end

  // NOTE: the storage array is not reset; the cleared pointers and count make
  // stale contents unreachable, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {host_wr_addr, host_wr_data};
  end

  assign host_ready    = (r_count < DEPTH_C);
  assign param_wr_en   = r_wr_en;
  assign param_wr_addr = r_wr_addr;
  assign param_wr_data = r_wr_data;
  assign busy          = r_busy;
  assign overflow      = r_overflow;
  assign batch_split   = r_batch_split;

endmodule
